// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over UART bytes,
// writes it to RAM, answers ACK/NAK. Optional checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 16384,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA,
    parameter logic [7:0]  NAK_BYTE  = 8'hEE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        rx_ferr,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done
);

    // state    | meaning
    // S_HDR    | collecting the 4-byte word count
    // S_DATA   | collecting payload words, one RAM write per word
    // S_FINISH | payload complete (waits for checksum byte if enabled)
    // S_ACK    | waiting for transmitter idle, then sends ACK_BYTE
    // S_NAK    | waiting for transmitter idle, then sends NAK_BYTE and rearms
    // S_DONE   | load complete, everything ignored until reset
    typedef enum logic [2:0] {S_HDR, S_DATA, S_FINISH, S_ACK, S_NAK, S_DONE} state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] asm_word;
    logic [31:0] count;
    logic [31:0] word_cnt;
    logic [31:0] addr;
    logic [31:0] full_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    // Only meaningful on the fourth byte of a word.
    assign full_word = {rx_data, asm_word};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_HDR;
            byte_idx  <= 2'd0;
            asm_word  <= 24'd0;
            count     <= 32'd0;
            word_cnt  <= 32'd0;
            addr      <= BASE_ADDR;
            tx_data   <= 8'd0;
            tx_start  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                S_HDR, S_DATA: begin
                    if (rx_ready) begin
                        if (rx_ferr) begin
                            state <= S_NAK;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0:    asm_word[7:0]   <= rx_data;
                                2'd1:    asm_word[15:8]  <= rx_data;
                                2'd2:    asm_word[23:16] <= rx_data;
                                default: asm_word        <= asm_word;
                            endcase
`ifdef LOADER_CHECKSUM_EN
                            if (state == S_DATA)
                                sum <= sum + rx_data;
`endif
                            if (byte_idx == 2'd3) begin
                                if (state == S_HDR) begin
                                    count <= full_word;
                                    if (full_word > MAX_WORDS)
                                        state <= S_NAK;
                                    else if (full_word == 32'd0)
                                        state <= S_FINISH;
                                    else
                                        state <= S_DATA;
                                end else begin
                                    mem_en    <= 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= addr;
                                    mem_wdata <= full_word;
                                    addr      <= addr + 32'd4;
                                    word_cnt  <= word_cnt + 32'd1;
                                    if (word_cnt + 32'd1 == count)
                                        state <= S_FINISH;
                                end
                            end
                        end
                    end
                end
                S_FINISH: begin
`ifdef LOADER_CHECKSUM_EN
                    if (rx_ready) begin
                        if (!rx_ferr && rx_data == sum)
                            state <= S_ACK;
                        else
                            state <= S_NAK;
                    end
`else
                    state <= S_ACK;
`endif
                end
                S_ACK: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= ACK_BYTE;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_NAK: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= NAK_BYTE;
                        byte_idx <= 2'd0;
                        word_cnt <= 32'd0;
                        addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= 8'd0;
`endif
                        state    <= S_HDR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: vector table of whole loads plus hand sequences
// for transmitter back-pressure, async reset mid-load, header boundary and checksum.
module tb_uart_program_loader;

    localparam int unsigned MAX_WORDS = 16384;
    localparam logic [7:0]  ACK = 8'hAA;
    localparam logic [7:0]  NAK = 8'hEE;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        rx_ferr = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;

    always #5 clk = ~clk;

    uart_program_loader #(
        .BASE_ADDR(32'h0), .MAX_WORDS(MAX_WORDS), .ACK_BYTE(ACK), .NAK_BYTE(NAK)
    ) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done)
    );

    typedef struct {
        logic [31:0]      n;
        int               nsend;
        logic [3:0][31:0] w;
        int               ferr_pos;
        int               gap;
        logic [7:0]       cs_bias;
        int               exp_writes;
        logic [7:0]       exp_tx;
        logic             exp_done;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          tx_cnt = 0;
    logic [7:0]  tx_last = 8'd0;
    int          en_bad = 0;

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (mem_en != mem_we) en_bad++;
        if (tx_start) begin
            tx_cnt++;
            tx_last = tx_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] n, int nsend, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, int ferr_pos, int gap, int exp_writes,
                                logic [7:0] exp_tx, logic exp_done);
        vec_t v;
        v.n = n; v.nsend = nsend; v.w = {32'h0, w2, w1, w0};
        v.ferr_pos = ferr_pos; v.gap = gap; v.cs_bias = 8'd0;
        v.exp_writes = exp_writes; v.exp_tx = exp_tx; v.exp_done = exp_done;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic ferr, input int gap);
        rx_data = b; rx_ready = 1'b1; rx_ferr = ferr;
        @(negedge clk);
        rx_ready = 1'b0; rx_ferr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; rx_ready = 1'b0; rx_ferr = 1'b0; tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] q[$];
        logic [7:0] cs;
        cs = 8'd0;
        for (int i = 0; i < 4; i++) q.push_back(v.n[8*i +: 8]);
        for (int k = 0; k < v.nsend; k++)
            for (int i = 0; i < 4; i++) begin
                q.push_back(v.w[k][8*i +: 8]);
                cs = cs + v.w[k][8*i +: 8];
            end
`ifdef LOADER_CHECKSUM_EN
        if (v.ferr_pos < 0 && v.n <= MAX_WORDS) q.push_back(cs + v.cs_bias);
`endif
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], i == v.ferr_pos, v.gap);
            if (i == v.ferr_pos) break;
        end
    endtask

    task automatic wait_tx(input int target, input string name);
        int b;
        b = 0;
        while (tx_cnt < target && b < 300) begin
            @(negedge clk);
            b++;
        end
        check({name, " tx timeout"}, 32'(tx_cnt >= target), 32'd1);
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        int wb, tb;
        wb = wr_addr.size();
        tb = tx_cnt;
        run_vec(v);
        wait_tx(tb + 1, tag);
        repeat (5) @(negedge clk);
        check({tag, " writes"}, 32'(wr_addr.size() - wb), 32'(v.exp_writes));
        for (int k = 0; k < v.exp_writes && wb + k < wr_addr.size(); k++) begin
            check($sformatf("%s addr%0d", tag, k), wr_addr[wb + k], 32'(k * 4));
            check($sformatf("%s data%0d", tag, k), wr_data[wb + k], v.w[k]);
        end
        check({tag, " tx count"}, 32'(tx_cnt - tb), 32'd1);
        check({tag, " tx byte"}, {24'd0, tx_last}, {24'd0, v.exp_tx});
        check({tag, " done"}, {31'd0, done}, {31'd0, v.exp_done});
        check({tag, " en/we"}, 32'(en_bad), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int wb, tb;
        vec_t v;

        vecs[0] = mk(32'd1, 1, 32'h00000013, 32'h0, 32'h0, -1, 2, 1, ACK, 1'b1);
        vecs[1] = mk(32'd3, 3, 32'h11223344, 32'h55667788, 32'hDEADBEEF, -1, 2, 3, ACK, 1'b1);
        vecs[2] = mk(32'd3, 3, 32'h11223344, 32'h55667788, 32'hDEADBEEF, -1, 0, 3, ACK, 1'b1);
        vecs[3] = mk(MAX_WORDS + 1, 0, 32'h0, 32'h0, 32'h0, -1, 2, 0, NAK, 1'b0);
        vecs[4] = mk(32'd2, 2, 32'hA5A50001, 32'h0000BBBB, 32'h0, 9, 2, 1, NAK, 1'b0);
        vecs[5] = mk(32'd0, 0, 32'h0, 32'h0, 32'h0, -1, 2, 0, ACK, 1'b1);
        vecs[6] = mk(32'd2, 2, 32'h01010101, 32'h02020202, 32'h0, 1, 1, 0, NAK, 1'b0);

        // Reset values.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst mem_en", {31'd0, mem_en}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst tx_start", {31'd0, tx_start}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // Rejected header, then a good load without reset.
        do_reset();
        run_and_check(vecs[3], "nak_hdr");
        run_and_check(mk(32'd1, 1, 32'hC0FFEE01, 32'h0, 32'h0, -1, 2, 1, ACK, 1'b1), "after_nak");

        // Framing error mid-word, then a good load must restart at the base address.
        do_reset();
        run_and_check(vecs[4], "ferr");
        run_and_check(mk(32'd1, 1, 32'h00000077, 32'h0, 32'h0, -1, 1, 1, ACK, 1'b1), "after_ferr");

        // Header N == MAX_WORDS is accepted (no NAK).
        do_reset();
        tb = tx_cnt;
        send_byte(8'h00, 1'b0, 1); send_byte(8'h40, 1'b0, 1);
        send_byte(8'h00, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
        repeat (10) @(negedge clk);
        check("max hdr no tx", 32'(tx_cnt - tb), 32'd0);

        // Transmitter busy at ACK time, then extra bytes after done.
        do_reset();
        tx_busy = 1'b1;
        wb = wr_addr.size();
        tb = tx_cnt;
        run_vec(mk(32'd1, 1, 32'h0BADC0DE, 32'h0, 32'h0, -1, 1, 1, ACK, 1'b1));
        repeat (100) @(negedge clk);
        check("busy no tx", 32'(tx_cnt - tb), 32'd0);
        check("busy no done", {31'd0, done}, 32'd0);
        tx_busy = 1'b0;
        wait_tx(tb + 1, "busy");
        repeat (3) @(negedge clk);
        check("busy tx once", 32'(tx_cnt - tb), 32'd1);
        check("busy tx byte", {24'd0, tx_last}, {24'd0, ACK});
        check("busy done", {31'd0, done}, 32'd1);
        check("busy writes", 32'(wr_addr.size() - wb), 32'd1);
        for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i), 1'b0, 0);
        repeat (5) @(negedge clk);
        check("post done writes", 32'(wr_addr.size() - wb), 32'd1);
        check("post done tx", 32'(tx_cnt - tb), 32'd1);
        check("post done sticky", {31'd0, done}, 32'd1);

        // Asynchronous reset right after a write pulse.
        do_reset();
        send_byte(8'h02, 1'b0, 0); send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0); send_byte(8'h00, 1'b0, 0);
        send_byte(8'h0D, 1'b0, 0); send_byte(8'hF0, 1'b0, 0);
        send_byte(8'hFE, 1'b0, 0); send_byte(8'hCA, 1'b0, 0);
        check("midrst pre we", {31'd0, mem_we}, 32'd1);
        check("midrst pre wdata", mem_wdata, 32'hCAFEF00D);
        #2 rstn = 1'b0;
        #1;
        check("midrst we", {31'd0, mem_we}, 32'd0);
        check("midrst wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_and_check(mk(32'd1, 1, 32'h12345678, 32'h0, 32'h0, -1, 1, 1, ACK, 1'b1), "after_rst");

`ifdef LOADER_CHECKSUM_EN
        // Checksum 01+02+03+04 = 0x0A matches; 0x0B does not.
        do_reset();
        run_and_check(mk(32'd1, 1, 32'h04030201, 32'h0, 32'h0, -1, 1, 1, ACK, 1'b1), "cs_good");
        do_reset();
        v = mk(32'd1, 1, 32'h04030201, 32'h0, 32'h0, -1, 1, 1, NAK, 1'b0);
        v.cs_bias = 8'd1;
        run_and_check(v, "cs_bad");
`else
        v = vecs[0];
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
